periph_bus_master: RTL

Bus initiator for the peripheral bus that GPIO and the other memory-mapped peripherals respond on. It accepts one load/store request at a time from the core's load/store unit and decodes the peripheral window. It drives per-slave chip-select, byte write enables, read enable, write data and a 17-bit offset address. On loads it samples the slave's read data, extracts the addressed lane and sign- or zero-extends it before returning it to the core.

---
 rtl/periph_bus_defs.sv | 23 ++
 rtl/periph_lane_align.sv | 53 +++++
 rtl/periph_bus_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/periph_bus_defs.sv
// Shared definitions for the peripheral bus initiator:
// access size codes, FSM state encoding, slave indices and window base.
package periph_bus_defs;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [11:0] BASE_HI_DEF = 12'h100;

   localparam int SLV_GPIO  = 0;
   localparam int SLV_TIMER = 1;
   localparam int SLV_UART  = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD1  = 3'd2,
      ST_RD2  = 3'd3,
      ST_RESP = 3'd4
   } state_t;

endpackage

// File: rtl/periph_lane_align.sv
// Byte-lane steering for the peripheral bus (purely combinational).
// Ports: i_st_* store request -> o_st_data/o_st_be/o_misal;
//        i_ld_* registered load info + slave data -> o_ld_data.
module periph_lane_align
   import periph_bus_defs::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_lo,
   input  logic [31:0] i_st_wdata,
   output logic [31:0] o_st_data,
   output logic [3:0]  o_st_be,
   output logic        o_misal,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_lo,
   input  logic        i_ld_uns,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_sh;

   assign o_misal = ((i_st_size == SZ_H) & i_st_lo[0])
                  | ((i_st_size == SZ_W) & (i_st_lo != 2'b00));

   always_comb begin
      o_st_data = i_st_wdata;
      o_st_be   = 4'b1111;
      unique case (i_st_size)
         SZ_B: begin
            o_st_data = {4{i_st_wdata[7:0]}};
            o_st_be   = 4'b0001 << i_st_lo;
         end
         SZ_H: begin
            o_st_data = {2{i_st_wdata[15:0]}};
            o_st_be   = 4'b0011 << i_st_lo;
         end
         default: ;
      endcase
   end

   // Word loads are always aligned, so the shift is a no-op for them.
   assign w_sh = i_ld_rdata >> {i_ld_lo, 3'b000};

   always_comb begin
      o_ld_data = w_sh;
      unique case (i_ld_size)
         SZ_B: o_ld_data = {{24{w_sh[7] & ~i_ld_uns}}, w_sh[7:0]};
         SZ_H: o_ld_data = {{16{w_sh[15] & ~i_ld_uns}}, w_sh[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: one load/store at a time, window decode,
// registered slave strobes, lane-extracted load data back to the core.
// Ports: clk/rst; req_* core request; rsp_* completion; bus_* slave bus.
module periph_bus_master
   import periph_bus_defs::*;
#(
   parameter logic [11:0] BASE_HI = BASE_HI_DEF,
   parameter int          N_SLV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   output logic             rsp_err,
   output logic [31:0]      rsp_rdata,
   output logic [N_SLV-1:0] bus_ce,
   output logic [3:0]       bus_we,
   output logic             bus_re,
   output logic [31:0]      bus_wdata,
   output logic [16:0]      bus_addr,
   input  logic [31:0]      bus_rdata
);

   localparam logic [N_SLV-1:0] ONE = 1;

   state_t r_state;
   state_t w_state_nxt;

   logic [1:0]       r_size;
   logic [1:0]       r_lo;
   logic             r_uns;
   logic [N_SLV-1:0] r_sel;

   logic [2:0]       w_idx;
   logic             w_accept;
   logic             w_err;
   logic             w_misal;
   logic [N_SLV-1:0] w_onehot;
   logic [N_SLV-1:0] w_sel;
   logic [31:0]      w_st_data;
   logic [3:0]       w_st_be;
   logic [31:0]      w_ld_data;
   logic [N_SLV-1:0] w_ce_nxt;
   logic [3:0]       w_we_nxt;
   logic             w_re_nxt;

   assign w_idx     = req_addr[19:17];
   assign req_ready = (r_state == ST_IDLE) & ~rst;
   assign w_accept  = req_valid & req_ready;
   assign w_onehot  = ONE << w_idx;
   assign w_err     = (req_addr[31:20] != BASE_HI)
                    | (int'(w_idx) >= N_SLV)
                    | (req_size == 2'd3)
                    | w_misal;

   // Slave select comes straight from the request on the accept
   // edge, and from the captured copy for the second read cycle.
   assign w_sel = (r_state == ST_IDLE) ? w_onehot : r_sel;

   periph_lane_align u_align (
      .i_st_size  (req_size),
      .i_st_lo    (req_addr[1:0]),
      .i_st_wdata (req_wdata),
      .o_st_data  (w_st_data),
      .o_st_be    (w_st_be),
      .o_misal    (w_misal),
      .i_ld_size  (r_size),
      .i_ld_lo    (r_lo),
      .i_ld_uns   (r_uns),
      .i_ld_rdata (bus_rdata),
      .o_ld_data  (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err)       w_state_nxt = ST_RESP;
               else if (req_we) w_state_nxt = ST_WR;
               else             w_state_nxt = ST_RD1;
            end
         end
         ST_WR:   w_state_nxt = ST_RESP;
         ST_RD1:  w_state_nxt = ST_RD2;
         ST_RD2:  w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered, so they
   // line up with the state they belong to.
   always_comb begin
      w_ce_nxt = '0;
      w_we_nxt = '0;
      w_re_nxt = 1'b0;
      unique case (w_state_nxt)
         ST_WR: begin
            w_ce_nxt = w_sel;
            w_we_nxt = w_st_be;
         end
         ST_RD1, ST_RD2: begin
            w_ce_nxt = w_sel;
            w_re_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_ce    <= '0;
         bus_we    <= '0;
         bus_re    <= 1'b0;
         bus_wdata <= '0;
         bus_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         r_size    <= '0;
         r_lo      <= '0;
         r_uns     <= 1'b0;
         r_sel     <= '0;
      end else begin
         bus_ce    <= w_ce_nxt;
         bus_we    <= w_we_nxt;
         bus_re    <= w_re_nxt;
         rsp_valid <= (w_state_nxt == ST_RESP);
         rsp_err   <= w_accept & w_err;
         rsp_rdata <= (r_state == ST_RD2) ? w_ld_data : '0;
         if (w_accept) begin
            r_size <= req_size;
            r_lo   <= req_addr[1:0];
            r_uns  <= req_unsigned;
            r_sel  <= w_onehot;
            if (!w_err) begin
               bus_addr <= {req_addr[16:2], 2'b00};
               if (req_we) bus_wdata <= w_st_data;
            end
         end
      end
   end

endmodule
